// File: rtl/rom_seq_ctrl.sv
// rom_seq_ctrl: walks an external combinational pattern ROM at a programmable
// step rate and registers each word onto pattern with a one-cycle valid strobe.
// Walk modes: up-wrap, down-wrap, ping-pong, single-shot up.
module rom_seq_ctrl #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic [DIV_W-1:0]  rate,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] pattern,
    output logic              pattern_valid,
    output logic              busy,
    output logic              done
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [1:0] M_UP    = 2'b00;
    localparam logic [1:0] M_DOWN  = 2'b01;
    localparam logic [1:0] M_PING  = 2'b10;
    localparam logic [1:0] M_SINGLE = 2'b11;

    localparam logic [ADDR_W-1:0] AMAX = '1;
    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);
    localparam logic [DIV_W-1:0]  DONE = DIV_W'(1);

    state_t            state;
    logic [DIV_W-1:0]  div;
    logic [DIV_W-1:0]  rate_l;
    logic [1:0]        mode_l;
    logic              dir_dn;

    logic [ADDR_W-1:0] next_addr;
    logic              next_dn;

    // Address (and ping-pong direction) to move to on the next step edge
    always_comb begin
        next_addr = rom_addr + ONE;
        next_dn   = dir_dn;
        case (mode_l)
            M_DOWN: next_addr = rom_addr - ONE;
            M_PING: begin
                if (!dir_dn) begin
                    // turning at MAX so the endpoint is emitted only once
                    if (rom_addr == AMAX) begin
                        next_addr = rom_addr - ONE;
                        next_dn   = 1'b1;
                    end
                end else if (rom_addr == '0) begin
                    next_dn = 1'b0;
                end else begin
                    next_addr = rom_addr - ONE;
                end
            end
            default: ;
        endcase
    end

    // Sequencer FSM with all outputs registered alongside the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rom_addr      <= '0;
            pattern       <= '0;
            pattern_valid <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            div           <= '0;
            rate_l        <= '0;
            mode_l        <= M_UP;
            dir_dn        <= 1'b0;
        end else begin
            pattern_valid <= 1'b0;
            done          <= 1'b0;
            case (state)
                IDLE: begin
                    // start together with stop is treated as no request
                    if (start && !stop) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        mode_l   <= mode;
                        rate_l   <= rate;
                        div      <= '0;
                        rom_addr <= (mode == M_DOWN) ? AMAX : '0;
                        dir_dn   <= (mode == M_DOWN);
                    end
                end
                RUN: begin
                    if (stop) begin
                        // abort wins over a coincident step; pattern keeps last word
                        state    <= IDLE;
                        busy     <= 1'b0;
                        rom_addr <= '0;
                        div      <= '0;
                        dir_dn   <= 1'b0;
                    end else if (div == rate_l) begin
                        pattern       <= rom_data;
                        pattern_valid <= 1'b1;
                        div           <= '0;
                        if (mode_l == M_SINGLE && rom_addr == AMAX) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            rom_addr <= '0;
                            dir_dn   <= 1'b0;
                        end else begin
                            rom_addr <= next_addr;
                            dir_dn   <= next_dn;
                        end
                    end else begin
                        div <= div + DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_seq_ctrl.sv
// Self-checking bench for rom_seq_ctrl: directed scenarios plus randomized
// sequences compared cycle by cycle against a step-count reference model.
module tb_rom_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [1:0]  mode;
    logic [15:0] rate;
    logic [2:0]  rom_addr;
    logic [7:0]  rom_data;
    logic [7:0]  pattern;
    logic        pattern_valid;
    logic        busy;
    logic        done;

    int          n_chk = 0;
    int          n_err = 0;
    logic [7:0]  exp_pat;

    rom_seq_ctrl #(.ADDR_W(3), .DATA_W(8), .DIV_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
        .rate(rate), .rom_addr(rom_addr), .rom_data(rom_data), .pattern(pattern),
        .pattern_valid(pattern_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // one-hot pattern ROM
    assign rom_data = 8'd1 << rom_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input int a, input logic [7:0] p,
                             input logic v, input logic b, input logic d);
        check({tag, ".addr"},  rom_addr, a);
        check({tag, ".pat"},   pattern, p);
        check({tag, ".valid"}, pattern_valid, v);
        check({tag, ".busy"},  busy, b);
        check({tag, ".done"},  done, d);
    endtask

    // address visited at step n of the walk for a mode
    function automatic int addr_of(input int m, input int n);
        int p;
        case (m)
            0: return n % 8;
            1: return 7 - (n % 8);
            2: begin
                p = n % 14;
                return (p < 8) ? p : 14 - p;
            end
            default: return (n < 8) ? n : 0;
        endcase
    endfunction

    // Accept a sequence, then model every edge until stop_at (0 = none,
    // only meaningful for single-shot). Mode/rate are scrambled and stray
    // start pulses are injected during RUN; they must have no effect.
    task automatic run_seq(input int m, input int r, input int stop_at);
        int k;
        int s;
        bit fin;
        @(negedge clk);
        start = 1'b1; stop = 1'b0; mode = 2'(m); rate = 16'(r);
        @(negedge clk);
        start = 1'b0;
        check_out("accept", addr_of(m, 0), exp_pat, 1'b0, 1'b1, 1'b0);
        k = 0;
        fin = 1'b0;
        while (!fin) begin
            k++;
            mode  = 2'($urandom);
            rate  = 16'($urandom_range(0, 5));
            start = ($urandom_range(0, 3) == 0);
            stop  = (k == stop_at);
            @(negedge clk);
            if (k == stop_at) begin
                check_out("stop", 0, exp_pat, 1'b0, 1'b0, 1'b0);
                fin = 1'b1;
            end else if (k % (r + 1) == 0) begin
                s = k / (r + 1);
                exp_pat = 8'd1 << addr_of(m, s - 1);
                if (m == 3 && s == 8) begin
                    check_out("last", 0, exp_pat, 1'b1, 1'b0, 1'b1);
                    fin = 1'b1;
                end else begin
                    check_out("step", addr_of(m, s), exp_pat, 1'b1, 1'b1, 1'b0);
                end
            end else begin
                check_out("wait", addr_of(m, k / (r + 1)), exp_pat, 1'b0, 1'b1, 1'b0);
            end
            if (k > 4000) begin
                check("runaway", k, 0);
                fin = 1'b1;
            end
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            check_out("idle", 0, exp_pat, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        int m;
        int r;
        int sa;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'b00; rate = 16'd0;
        exp_pat = 8'h00;
        #12;
        check_out("reset", 0, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // start+stop together stays idle
        start = 1'b1; stop = 1'b1; mode = 2'b00;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        check_out("startstop", 0, exp_pat, 1'b0, 1'b0, 1'b0);

        run_seq(0, 0, 10);       // up-wrap every cycle, stop on a step edge
        idle(2);
        run_seq(1, 3, 37);       // down-wrap, every 4 cycles
        idle(2);
        run_seq(2, 0, 17);       // ping-pong
        idle(2);
        run_seq(3, 1, 0);        // single-shot to completion
        idle(3);
        run_seq(0, 2, 6);        // stop on a step edge, stray starts
        idle(2);

        // async reset mid-RUN, between edges
        @(negedge clk);
        start = 1'b1; mode = 2'b00; rate = 16'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst.pat", pattern, 8'h01);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_pat = 8'h00;
        check_out("midrst", 0, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        run_seq(3, 0, 0);
        idle(2);

        // randomized sequences
        repeat (30) begin
            m = $urandom_range(0, 3);
            r = $urandom_range(0, 4);
            if (m == 3)
                sa = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 8 * (r + 1));
            else
                sa = $urandom_range(1, 20 * (r + 1));
            run_seq(m, r, sa);
            idle($urandom_range(1, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
